// File: rtl/la_capture_core_if.sv
// Host readout bus of the logic-analyzer capture core.
//   rd_addr_i : logical read index, 0 = oldest valid sample
//   rd_en_i   : read strobe
//   rd_data_o : registered read data, valid the cycle after rd_en_i
// The host drives the master side; the capture core is the slave.
interface la_capture_core_if #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 10
);
    logic [DEPTH_LOG2-1:0] rd_addr_i;
    logic                  rd_en_i;
    logic [DATA_W-1:0]     rd_data_o;

    modport master (output rd_addr_i, output rd_en_i, input rd_data_o);
    modport slave  (input rd_addr_i, input rd_en_i, output rd_data_o);
endinterface

// File: rtl/la_capture_core.sv
// Logic-analyzer capture core: circular sample buffer with mask/value
// trigger (level or edge), forced trigger, post-trigger window and an
// oldest-first readout port.
//   clk_i, rst_i          : sample clock, synchronous active-high reset
//   data_i                : probe sample, stored every ARMED/POST cycle
//   arm_i                 : start a new capture (latches trigger config)
//   trig_mask_i/value_i   : masked compare value
//   trig_edge_i           : 0 level, 1 rising-edge of match
//   force_trig_i          : unconditional trigger while ARMED
//   post_cnt_i            : samples stored after the trigger sample
//   rd_bus                : readout bus (slave side)
//   state_o, done_o       : capture state, DONE flag
//   valid_count_o         : valid samples in buffer (saturates at depth)
//   trig_idx_o            : logical index of the trigger sample
//
// state | meaning
// IDLE  | after reset, nothing captured
// ARMED | storing samples, watching for the trigger
// POST  | storing the post-trigger window
// DONE  | capture frozen, waiting for re-arm
module la_capture_core #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  arm_i,
    input  logic [DATA_W-1:0]     trig_mask_i,
    input  logic [DATA_W-1:0]     trig_value_i,
    input  logic                  trig_edge_i,
    input  logic                  force_trig_i,
    input  logic [DEPTH_LOG2-1:0] post_cnt_i,
    la_capture_core_if.slave      rd_bus,
    output logic [1:0]            state_o,
    output logic                  done_o,
    output logic [DEPTH_LOG2:0]   valid_count_o,
    output logic [DEPTH_LOG2-1:0] trig_idx_o
);
    localparam int                DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_W-1:0]     r_mask;
    logic [DATA_W-1:0]     r_value;
    logic                  r_edge;
    logic [DEPTH_LOG2-1:0] r_post;
    logic [DEPTH_LOG2-1:0] r_post_left;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_valid_cnt;
    logic [DEPTH_LOG2-1:0] r_trig_phys;
    logic                  r_trig_seen;
    logic                  r_prev_match;
    logic [DATA_W-1:0]     r_rd_data;
    logic [DATA_W-1:0]     r_mem [DEPTH];

    logic                  w_match;
    logic                  w_trig;
    logic                  w_wr_en;
    logic                  w_trig_hit;
    logic [DEPTH_LOG2-1:0] w_oldest;
    logic [DEPTH_LOG2-1:0] w_rd_phys;

    assign w_match = ((data_i ^ r_value) & r_mask) == '0;
    assign w_trig  = r_edge ? (w_match & ~r_prev_match) : w_match;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // arm_i overrides everything, including a trigger in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_trig_hit  = 1'b0;
        if (arm_i) begin
            w_state_nxt = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    w_wr_en = 1'b1;
                    if (w_trig || force_trig_i) begin
                        w_trig_hit  = 1'b1;
                        w_state_nxt = (r_post == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    w_wr_en = 1'b1;
                    if (r_post_left == DEPTH_LOG2'(1)) w_state_nxt = ST_DONE;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mask       <= '0;
            r_value      <= '0;
            r_edge       <= 1'b0;
            r_post       <= '0;
            r_post_left  <= '0;
            r_wr_ptr     <= '0;
            r_valid_cnt  <= '0;
            r_trig_phys  <= '0;
            r_trig_seen  <= 1'b0;
            r_prev_match <= 1'b0;
        end else if (arm_i) begin
            r_mask       <= trig_mask_i;
            r_value      <= trig_value_i;
            r_edge       <= trig_edge_i;
            r_post       <= post_cnt_i;
            r_post_left  <= '0;
            r_wr_ptr     <= '0;
            r_valid_cnt  <= '0;
            r_trig_phys  <= '0;
            r_trig_seen  <= 1'b0;
            r_prev_match <= 1'b1;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_valid_cnt != C_FULL) r_valid_cnt <= r_valid_cnt + 1'b1;
            end
            if (r_state == ST_ARMED) r_prev_match <= w_match;
            if (w_trig_hit) begin
                r_trig_phys <= r_wr_ptr;
                r_trig_seen <= 1'b1;
                r_post_left <= r_post;
            end else if (r_state == ST_POST) begin
                r_post_left <= r_post_left - 1'b1;
            end
        end
    end

    // Buffer is never cleared; only the valid window is meaningful.
    always_ff @(posedge clk_i) begin
        if (w_wr_en && !rst_i) r_mem[r_wr_ptr] <= data_i;
    end

    // Once the buffer has wrapped the oldest sample sits at the write pointer.
    assign w_oldest  = (r_valid_cnt == C_FULL) ? r_wr_ptr : '0;
    assign w_rd_phys = w_oldest + rd_bus.rd_addr_i;

    // Non-blocking read of the array gives read-first on address collision.
    always_ff @(posedge clk_i) begin
        if (rst_i)                r_rd_data <= '0;
        else if (rd_bus.rd_en_i)  r_rd_data <= r_mem[w_rd_phys];
    end

    assign rd_bus.rd_data_o = r_rd_data;
    assign state_o          = r_state;
    assign done_o           = (r_state == ST_DONE);
    assign valid_count_o    = r_valid_cnt;
    assign trig_idx_o       = r_trig_seen ? (r_trig_phys - w_oldest) : '0;
endmodule

// File: tb/tb_la_capture_core.sv
// Self-checking bench for la_capture_core (DATA_W=8, DEPTH_LOG2=4).
module tb_la_capture_core;
    localparam int DW = 8;
    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [DW-1:0] data_i;
    logic          arm_i;
    logic [DW-1:0] trig_mask_i;
    logic [DW-1:0] trig_value_i;
    logic          trig_edge_i;
    logic          force_trig_i;
    logic [DL-1:0] post_cnt_i;
    logic [1:0]    state_o;
    logic          done_o;
    logic [DL:0]   valid_count_o;
    logic [DL-1:0] trig_idx_o;

    la_capture_core_if #(.DATA_W(DW), .DEPTH_LOG2(DL)) u_rd_if ();

    la_capture_core #(.DATA_W(DW), .DEPTH_LOG2(DL)) u_dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .data_i        (data_i),
        .arm_i         (arm_i),
        .trig_mask_i   (trig_mask_i),
        .trig_value_i  (trig_value_i),
        .trig_edge_i   (trig_edge_i),
        .force_trig_i  (force_trig_i),
        .post_cnt_i    (post_cnt_i),
        .rd_bus        (u_rd_if),
        .state_o       (state_o),
        .done_o        (done_o),
        .valid_count_o (valid_count_o),
        .trig_idx_o    (trig_idx_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] value;
        logic       edge_m;
        int         post;
        int         force_at;
        int         trig_n;
        int         valid;
        int         idx;
    } rec_t;

    rec_t       tbl [4];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Arms, then scrambles the config inputs to prove they were latched.
    task automatic arm(input logic [7:0] m, input logic [7:0] v,
                       input logic e, input int p);
        trig_mask_i  = m;
        trig_value_i = v;
        trig_edge_i  = e;
        post_cnt_i   = DL'(p);
        arm_i        = 1'b1;
        tick();
        arm_i        = 1'b0;
        trig_mask_i  = ~m;
        trig_value_i = ~v;
        trig_edge_i  = ~e;
        post_cnt_i   = DL'(p + 3);
    endtask

    task automatic read_chk(input int addr, input logic [7:0] exp);
        u_rd_if.rd_addr_i = DL'(addr);
        u_rd_if.rd_en_i   = 1'b1;
        exp_q.push_back(exp);
        tick();
        u_rd_if.rd_en_i   = 1'b0;
        chk("rd_data", int'(u_rd_if.rd_data_o), int'(exp_q.pop_front()));
    endtask

    task automatic run_capture(input rec_t r);
        int n;
        int cyc;
        int first;
        arm(r.mask, r.value, r.edge_m, r.post);
        chk("armed_state", int'(state_o), 1);
        n   = 0;
        cyc = 0;
        while (!done_o && cyc < 200) begin
            data_i       = 8'(n);
            force_trig_i = (n == r.force_at);
            tick();
            force_trig_i = 1'b0;
            n++;
            cyc++;
        end
        chk("done_latency", cyc, r.trig_n + 1 + r.post);
        chk("done_state", int'(state_o), 3);
        chk("valid_count", int'(valid_count_o), r.valid);
        chk("trig_idx", int'(trig_idx_o), r.idx);
        first = r.trig_n + r.post + 1 - r.valid;
        for (int i = 0; i < r.valid; i++) read_chk(i, 8'(first + i));
    endtask

    initial begin
        // mask   value  edge post force trig_n valid idx
        tbl[0] = '{8'hFF, 8'h25, 1'b0, 4, -1, 8'h25, 16, 11};
        tbl[1] = '{8'hFF, 8'h02, 1'b0, 3, -1, 2, 6, 2};
        tbl[2] = '{8'hFF, 8'h55, 1'b0, 0, 7, 7, 8, 7};
        tbl[3] = '{8'h00, 8'h33, 1'b0, 2, -1, 0, 3, 0};

        rst_i = 1'b1;
        data_i = '0;
        arm_i = 1'b0;
        trig_mask_i = '0;
        trig_value_i = '0;
        trig_edge_i = 1'b0;
        force_trig_i = 1'b0;
        post_cnt_i = '0;
        u_rd_if.rd_addr_i = '0;
        u_rd_if.rd_en_i = 1'b0;
        tick();
        tick();
        chk("rst_state", int'(state_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_valid", int'(valid_count_o), 0);
        chk("rst_trig_idx", int'(trig_idx_o), 0);
        chk("rst_rd_data", int'(u_rd_if.rd_data_o), 0);
        rst_i = 1'b0;
        tick();
        chk("idle_state", int'(state_o), 0);

        for (int t = 0; t < 4; t++) run_capture(tbl[t]);

        // read data holds while rd_en_i is low
        u_rd_if.rd_addr_i = '0;
        tick();
        chk("rd_hold", int'(u_rd_if.rd_data_o), 8'h02);

        // edge mode: held match never fires, fresh rising match does
        arm(8'h80, 8'h80, 1'b1, 0);
        data_i = 8'h80;
        for (int i = 0; i < 20; i++) tick();
        chk("edge_no_trig", int'(state_o), 1);
        data_i = 8'h00;
        tick();
        data_i = 8'h80;
        tick();
        chk("edge_done", int'(done_o), 1);
        chk("edge_valid", int'(valid_count_o), 16);
        chk("edge_trig_idx", int'(trig_idx_o), 15);
        read_chk(15, 8'h80);
        read_chk(14, 8'h00);

        // arm while DONE restarts
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("rearm_done", int'(done_o), 0);
        chk("rearm_state", int'(state_o), 1);

        // reset during POST, then a clean capture
        begin
            int n;
            int cyc;
            arm(8'hFF, 8'h25, 1'b0, 4);
            n = 0;
            cyc = 0;
            while (state_o != 2'd2 && cyc < 200) begin
                data_i = 8'(n);
                tick();
                n++;
                cyc++;
            end
            chk("post_reached", int'(state_o), 2);
            rst_i = 1'b1;
            tick();
            rst_i = 1'b0;
            chk("post_rst_state", int'(state_o), 0);
            chk("post_rst_done", int'(done_o), 0);
            chk("post_rst_valid", int'(valid_count_o), 0);
            chk("post_rst_trig_idx", int'(trig_idx_o), 0);
        end
        run_capture(tbl[0]);

        // arm coincident with a matching sample: restart wins
        arm(8'hFF, 8'h05, 1'b0, 0);
        data_i       = 8'h05;
        trig_mask_i  = 8'hFF;
        trig_value_i = 8'h05;
        trig_edge_i  = 1'b0;
        post_cnt_i   = '0;
        arm_i        = 1'b1;
        tick();
        arm_i        = 1'b0;
        chk("arm_prio_state", int'(state_o), 1);
        chk("arm_prio_valid", int'(valid_count_o), 0);
        chk("arm_prio_trig_idx", int'(trig_idx_o), 0);
        tick();
        chk("after_prio_done", int'(done_o), 1);
        chk("after_prio_valid", int'(valid_count_o), 1);
        read_chk(0, 8'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/la_capture_core.md
# la_capture_core

Parametrised on-chip logic-analyzer capture core: the next generation of the debug probe, generalised to DATA_W channels and a 2^DEPTH_LOG2-deep circular sample buffer. It adds a runtime mask/value trigger with level or edge mode, a forced trigger, pre-/post-trigger windowing and a host readout port addressed oldest-sample-first. It sits beside the design under test, sampling probe signals on the probed clock, and is read by the debug control logic.

## Interface
- DATA_W, 8: probe channels per sample
- DEPTH_LOG2, 10: buffer depth = 2^DEPTH_LOG2 samples
- clk_i  in  1  sample clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- data_i  in  DATA_W  probe sample, written every cycle in ARMED/POST
- arm_i  in  1  pulse; starts a new capture from any state
- trig_mask_i  in  DATA_W  bits taking part in the trigger compare
- trig_value_i  in  DATA_W  required value of masked bits
- trig_edge_i  in  1  0 = level mode, 1 = edge mode
- force_trig_i  in  1  unconditional trigger while ARMED
- post_cnt_i  in  DEPTH_LOG2  samples stored after the trigger sample
- rd_addr_i  in  DEPTH_LOG2  logical read index, 0 = oldest valid sample
- rd_en_i  in  1  read strobe
- rd_data_o  out  DATA_W  read data, registered
- state_o  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- done_o  out  1  high while in DONE
- valid_count_o  out  DEPTH_LOG2+1  valid samples in buffer (max 2^DEPTH_LOG2)
- trig_idx_o  out  DEPTH_LOG2  logical index of the trigger sample

## Operation
- arm_i latches trig_mask_i, trig_value_i, trig_edge_i and post_cnt_i; later changes are ignored until the next arm. Arm also clears wr_ptr, valid_count, trig_idx and done, sets prev_match=1, and enters ARMED.
- match = ((data_i ^ value) & mask) == 0. Level mode: trigger = match. Edge mode: trigger = match & ~prev_match. prev_match <= match each ARMED cycle. mask=0 in level mode triggers on the first armed sample.
- ARMED: write data_i at wr_ptr, wr_ptr++ (wraps mod depth), valid_count saturates at depth. On trigger or force_trig_i, that same sample is the trigger sample: record its physical address, go to POST (or to DONE if post_cnt=0).
- POST: write post_cnt samples, then DONE. Down-counter loaded with post_cnt.
- DONE: no writes; hold until arm_i or rst_i.
- Oldest physical address = wr_ptr if valid_count = depth, else 0. trig_idx_o = (trig_phys − oldest) mod depth. Read physical = (oldest + rd_addr_i) mod depth.
- Pre-trigger history is whatever fits: if trigger occurs early, valid_count < depth and no wrap occurred.
- arm_i while ARMED/POST aborts and restarts; arm_i has priority over trigger in the same cycle.
- rst_i: state IDLE, all counters and outputs 0; RAM contents undefined, not cleared. rst_i has priority over arm_i.

## Timing
- arm_i at cycle k → state_o=ARMED at k+1; first sample stored is data_i at k+1.
- Trigger sample at cycle t → POST at t+1, samples t+1..t+post_cnt stored, DONE (done_o=1) at t+post_cnt+1.
- rd_data_o valid one cycle after rd_en_i; holds when rd_en_i low. Reads allowed in any state; a read colliding with a write to the same address returns old data (read-first). Reads are guaranteed coherent only in DONE.
- Single-port write + single-port read RAM; one write and one read per cycle.
- Reset values: rd_data_o=0, state_o=0, done_o=0, valid_count_o=0, trig_idx_o=0.

## Test plan
- DATA_W=8, DEPTH_LOG2=4; data_i = count from 0x00 starting the cycle after arm; mask 0xFF, value 0x25, level, post 4 → DONE after sample 0x29; valid_count 16, trig_idx 11, reads 0..15 = 0x1A..0x29.
- Same stream, value 0x02, post 3 → valid_count 6, trig_idx 2, reads 0..5 = 0x00..0x05.
- Edge mode, mask 0x80, value 0x80, data held 0x80 for 20 cycles → no trigger; then 0x00, 0x80 → trigger on that 0x80 sample.
- Value 0x55 never presented, force_trig_i pulse on 8th armed sample, post 0 → DONE next cycle, valid_count 8, trig_idx 7.
- rst_i asserted in POST → next cycle state 0, done 0, valid_count 0; rearm then captures scenario 1 correctly.
- In DONE, pulse arm_i → done_o 0 and state ARMED next cycle; arm_i coincident with a matching sample while ARMED → restart, no trigger recorded.
